vcfg_unit: RTL
==============

# vcfg_unit

Vector configuration stage that sits directly downstream of the instruction decoder and consumes its field outputs for OP-V configuration instructions (vsetvli, vsetivli, vsetvl). It computes VLMAX and the new vl, and holds the architectural vl/vtype state used by the ALU and memory stages. It returns the new vl to the scalar core over a valid/ready writeback handshake.

## Interface
- VLEN, 256: vector register length in bits; a power of two, at least 64.
- ELEN, 32: maximum legal SEW in bits.
- XLEN, 32: scalar data width.
- clk  in  1  clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- opcode_mjr  in  7  must be 7'h57 for a config instruction.
- opcode_mnr  in  3  must be 3'b111 for a config instruction.
- dest  in  5  rd.
- src_1  in  5  rs1 index, or uimm AVL for vsetivli.
- vtype_11  in  11  zimm for vsetvli.
- vtype_10  in  10  zimm for vsetivli.
- cfg_type  in  2  insn[31:30]: 0x selects vsetvli, 11 selects vsetivli, 10 selects vsetvl.
- rs1_data  in  XLEN  scalar rs1 value, sampled at accept.
- rs2_data  in  XLEN  scalar rs2 value (vtype for vsetvl), sampled at accept.
- vl  out  XLEN  current vl.
- vtype  out  XLEN  current vtype; bit XLEN-1 is vill; [7]=vma, [6]=vta, [5:3]=vsew, [2:0]=vlmul.
- out_valid  out  1  rd writeback valid.
- out_ready  in  1  scalar core accepts the writeback.
- out_rd_addr  out  5  rd of the completed instruction.
- out_rd_data  out  XLEN  new vl.

## Operation
- Accept: `in_valid && in_ready`. A non-config instruction (opcode mismatch) is consumed with no effect and the FSM stays in IDLE.
- On accepting a config instruction, latch dest, the src_1 index/uimm, the instruction kind, rs1_data, and the raw vtype. Raw vtype is zero-extended vtype_11, zero-extended vtype_10, or rs2_data, according to cfg_type.
- AVL selection:
  - vsetivli: AVL = uimm (src_1).
  - vsetvli or vsetvl with rs1 != x0: AVL = rs1_data.
  - rs1 == x0 and rd != x0: AVL = all ones, so vl becomes VLMAX.
  - rs1 == x0 and rd == x0: AVL = current vl, so vl is kept but clamped to the new VLMAX.
- The new vtype is illegal (vill) if any of the following holds:
  - any reserved bit above [7] is nonzero;
  - vlmul == 3'b100;
  - SEW = 8<<vsew exceeds ELEN;
  - for fractional LMUL (101 = 1/8, 110 = 1/4, 111 = 1/2), SEW > ELEN*LMUL.
- VLMAX = (VLEN >> (3+vsew)) << vlmul for vlmul 0..3, and (VLEN >> (3+vsew)) >> (8-vlmul) for fractional LMUL. All shifts are unsigned with no overflow (VLMAX <= VLEN).
- Result: vl = min(AVL, VLMAX), unsigned XLEN compare. If illegal, vtype = 1<<(XLEN-1) and vl = 0.
- FSM states:
  - IDLE → CALC on accepting a config instruction.
  - CALC: compute and commit vl/vtype at the end of the cycle. Go to WB if rd != x0, else return to IDLE.
  - WB: out_valid = 1; go to IDLE when out_ready = 1.
- out_rd_addr and out_rd_data stay stable while out_valid is high and out_ready is low.
- Reset values: vl = 0, vtype = 1<<(XLEN-1), FSM = IDLE, out_valid = 0, out_rd_addr = 0, out_rd_data = 0. in_ready = 1 from the first cycle after reset.
- Reset in CALC or WB aborts the instruction: no commit and no writeback.

## Timing
- Accept at edge N. CALC runs in cycle N+1. vl/vtype update is visible, and out_valid rises, in cycle N+2.
- in_ready is low from N+1 until the cycle after the writeback handshake, or for N+1 only when rd == x0.
- Back-to-back throughput: one config instruction per 3 cycles (rd != x0, out_ready tied high), or per 2 cycles (rd == x0).
- in_ready is a registered function of state only; it has no combinational path from in_valid or out_ready.

## Test plan
- Legal clamp: VLEN=256, vsetvli rd=x5, rs1=x6 with rs1_data=20, zimm e32 m1 (0x010). Required: vl=8, vtype=0x10, out_valid at N+2 with out_rd_addr=5, out_rd_data=8.
- vsetivli: uimm=5, zimm e8 m2 (0x001). Required: VLMAX=64, vl=5, out_rd_data=5.
- VLMAX request: vsetvli rs1=x0, rd=x1, e16 mf2 (0x00F). Required: vl=8.
- Keep vl: with vl=8, issue vsetvli rs1=x0, rd=x0, e8 m1. Required: vl stays 8, vtype=0x0, no out_valid, in_ready back high at N+2.
- Illegal vtype: vsetvl with rs2_data=0x18 (e64 > ELEN). Required: vtype=0x8000_0000, vl=0, out_rd_data=0. Repeat with vlmul=4 and with bit 8 set; both required to give vill.
- Backpressure/reset: hold out_ready low for 3 cycles; out_valid and out_rd_data stay stable and in_ready stays low. Assert rst in CALC; required: vl/vtype unchanged from reset values, out_valid=0.

Source files
------------

// File: rtl/vcfg_unit.sv
// Vector configuration stage: executes vsetvli/vsetivli/vsetvl, holds vl/vtype,
// and returns the new vl to the scalar core over a valid/ready writeback.
module vcfg_unit #(
  parameter int unsigned VLEN = 256,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode_mjr,
  input  logic [2:0]      opcode_mnr,
  input  logic [4:0]      dest,
  input  logic [4:0]      src_1,
  input  logic [10:0]     vtype_11,
  input  logic [9:0]      vtype_10,
  input  logic [1:0]      cfg_type,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] vl,
  output logic [XLEN-1:0] vtype,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd_addr,
  output logic [XLEN-1:0] out_rd_data
);
  localparam int unsigned     VLMAX_W = $clog2(VLEN) + 1;
  localparam logic [XLEN-1:0] VILL    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WB} state_e;
  typedef enum logic [1:0] {K_VLI, K_IVLI, K_VL} kind_e;

  function automatic logic [VLMAX_W-1:0] calc_vlmax(input logic [2:0] vsew,
                                                    input logic [2:0] vlmul);
    logic [VLMAX_W-1:0] base;
    base = VLMAX_W'(VLEN) >> (3 + vsew);
    if (!vlmul[2]) return base << vlmul[1:0];
    return base >> (4'd8 - {1'b0, vlmul});
  endfunction

  function automatic logic calc_vill(input logic rsvd_nz, input logic [2:0] vsew,
                                     input logic [2:0] vlmul);
    logic [31:0] sew;
    logic        ill;
    sew = 32'd8 << vsew;
    ill = rsvd_nz || (vlmul == 3'b100) || (sew > ELEN);
    // Fractional LMUL: SEW must fit in ELEN*LMUL, i.e. SEW scaled by 1/LMUL <= ELEN.
    if (vlmul[2] && (vlmul != 3'b100) && ((sew << (4'd8 - {1'b0, vlmul})) > ELEN))
      ill = 1'b1;
    return ill;
  endfunction

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [4:0]      dest_q, dest_d;
  logic [4:0]      src1_q, src1_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] raw_vtype_q, raw_vtype_d;
  logic [XLEN-1:0] vl_q, vl_d;
  logic [XLEN-1:0] vtype_q, vtype_d;
  logic [4:0]      out_rd_addr_q, out_rd_addr_d;
  logic [XLEN-1:0] out_rd_data_q, out_rd_data_d;

  logic               is_cfg;
  logic               accept;
  logic               new_vill;
  logic [VLMAX_W-1:0] vlmax;
  logic [XLEN-1:0]    avl;
  logic [XLEN-1:0]    new_vl;
  logic [XLEN-1:0]    new_vtype;

  assign is_cfg = (opcode_mjr == 7'h57) && (opcode_mnr == 3'b111);
  assign accept = in_valid && in_ready;

  // Accept stage: capture operands of a config instruction
  always_comb begin
    kind_d      = kind_q;
    dest_d      = dest_q;
    src1_d      = src1_q;
    rs1_data_d  = rs1_data_q;
    raw_vtype_d = raw_vtype_q;
    if (accept && is_cfg) begin
      dest_d     = dest;
      src1_d     = src_1;
      rs1_data_d = rs1_data;
      if (!cfg_type[1]) begin
        kind_d      = K_VLI;
        raw_vtype_d = XLEN'(vtype_11);
      end else if (cfg_type[0]) begin
        kind_d      = K_IVLI;
        raw_vtype_d = XLEN'(vtype_10);
      end else begin
        kind_d      = K_VL;
        raw_vtype_d = rs2_data;
      end
    end
  end

  // Calc stage: VLMAX, AVL selection, legality and new vl/vtype
  always_comb begin
    new_vill = calc_vill(|raw_vtype_q[XLEN-1:8], raw_vtype_q[5:3], raw_vtype_q[2:0]);
    vlmax    = calc_vlmax(raw_vtype_q[5:3], raw_vtype_q[2:0]);
    if (kind_q == K_IVLI)    avl = XLEN'(src1_q);
    else if (src1_q != 5'd0) avl = rs1_data_q;
    else if (dest_q != 5'd0) avl = '1;
    else                     avl = vl_q;
    new_vl    = (avl < XLEN'(vlmax)) ? avl : XLEN'(vlmax);
    new_vtype = raw_vtype_q;
    if (new_vill) begin
      new_vl    = '0;
      new_vtype = VILL;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_cfg) state_d = ST_CALC;
      ST_CALC: state_d = (dest_q != 5'd0) ? ST_WB : ST_IDLE;
      ST_WB:   if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_WB);
  end

  // Commit stage: architectural state and held writeback payload
  always_comb begin
    vl_d          = vl_q;
    vtype_d       = vtype_q;
    out_rd_addr_d = out_rd_addr_q;
    out_rd_data_d = out_rd_data_q;
    if (state_q == ST_CALC) begin
      vl_d    = new_vl;
      vtype_d = new_vtype;
      if (dest_q != 5'd0) begin
        out_rd_addr_d = dest_q;
        out_rd_data_d = new_vl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vl_q          <= '0;
      vtype_q       <= VILL;
      out_rd_addr_q <= '0;
      out_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      vl_q          <= vl_d;
      vtype_q       <= vtype_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_rd_data_q <= out_rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    kind_q      <= kind_d;
    dest_q      <= dest_d;
    src1_q      <= src1_d;
    rs1_data_q  <= rs1_data_d;
    raw_vtype_q <= raw_vtype_d;
  end

  assign vl          = vl_q;
  assign vtype       = vtype_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_rd_data = out_rd_data_q;

endmodule
